// File: rtl/xgen_link_sched.sv
// ---------------------------------------------------------------------------
// xgen_link_sched
//
// Purpose:
//   Time-shares one bank of per-link xgen transform generators across all
//   robot links. For every link of a run (ascending or descending) it fetches
//   sin(q)/cos(q) from the trig unit, drives them with a one-hot link select
//   into the xgen bank, waits XGEN_LAT cycles for the bank to settle, then
//   presents the link's transform to the RNEA forward-pass consumer under
//   valid/ready.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   start_in, reverse_in         run request (sampled in IDLE) and direction
//   busy_out, done_out           run in progress / one-cycle completion pulse
//   sc_req_out, sc_link_out      trig request and requested link
//   sc_valid_in, sinq_in, cosq_in  trig response
//   xg_sel_out, xg_sinq_out, xg_cosq_out  registered drive of the xgen bank
//   out_valid_out, out_ready_in, out_link_out  consumer handshake
//   cyc_cnt_out                  run cycle count (performance build only)
//
// Configuration:
//   XGEN_SCHED_PERF_EN  when defined, cyc_cnt_out counts busy cycles of the
//                       current/last run (saturating); otherwise it is 0.
// ---------------------------------------------------------------------------
module xgen_link_sched #(
  parameter int WIDTH        = 32,
  parameter int DECIMAL_BITS = 16,
  parameter int NUM_LINKS    = 7,
  parameter int LINK_W       = 4,
  parameter int XGEN_LAT     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_in,
  input  logic                 reverse_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 sc_req_out,
  output logic [LINK_W-1:0]    sc_link_out,
  input  logic                 sc_valid_in,
  input  logic [WIDTH-1:0]     sinq_in,
  input  logic [WIDTH-1:0]     cosq_in,
  output logic [NUM_LINKS-1:0] xg_sel_out,
  output logic [WIDTH-1:0]     xg_sinq_out,
  output logic [WIDTH-1:0]     xg_cosq_out,
  output logic                 out_valid_out,
  input  logic                 out_ready_in,
  output logic [LINK_W-1:0]    out_link_out,
  output logic [15:0]          cyc_cnt_out
);

  // Catch illegal configurations at elaboration rather than in silicon.
  if (NUM_LINKS < 1 || NUM_LINKS > 15 || (1 << LINK_W) <= NUM_LINKS ||
      XGEN_LAT < 0 || XGEN_LAT > 15 || DECIMAL_BITS > WIDTH) begin : g_bad_params
    $error("xgen_link_sched: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, FETCH, SETTLE, EMIT, DONE} state_t;

  localparam logic [LINK_W-1:0]    FIRST_LINK = '0;
  localparam logic [LINK_W-1:0]    LAST_LINK  = LINK_W'(NUM_LINKS - 1);
  localparam logic [3:0]           LAT        = 4'(XGEN_LAT);
  localparam logic [NUM_LINKS-1:0] SEL_ONE    = NUM_LINKS'(1);

  state_t            state;
  logic [LINK_W-1:0] link;
  logic [3:0]        settle_cnt;
  logic              rev;

  logic              last_link;
  logic [LINK_W-1:0] next_link;

  // The end of a run depends on the direction latched at start, so the
  // counter only ever moves toward a valid terminal index and never wraps.
  assign last_link = rev ? (link == FIRST_LINK) : (link == LAST_LINK);
  assign next_link = rev ? (link - 1'b1) : (link + 1'b1);

  // Main scheduler. All outputs are registered here so the xgen bank and the
  // consumer see glitch-free, stable values for the whole emit window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      link          <= '0;
      settle_cnt    <= '0;
      rev           <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      sc_req_out    <= 1'b0;
      sc_link_out   <= '0;
      xg_sel_out    <= '0;
      xg_sinq_out   <= '0;
      xg_cosq_out   <= '0;
      out_valid_out <= 1'b0;
      out_link_out  <= '0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            busy_out    <= 1'b1;
            rev         <= reverse_in;
            link        <= reverse_in ? LAST_LINK : FIRST_LINK;
            sc_req_out  <= 1'b1;
            sc_link_out <= reverse_in ? LAST_LINK : FIRST_LINK;
            state       <= FETCH;
          end
        end

        FETCH: begin
          if (sc_valid_in) begin
            xg_sinq_out <= sinq_in;
            xg_cosq_out <= cosq_in;
            xg_sel_out  <= SEL_ONE << link;
            sc_req_out  <= 1'b0;
            settle_cnt  <= LAT;
            // With zero bank latency the transform is usable straight away.
            if (LAT == 4'd0) begin
              out_valid_out <= 1'b1;
              out_link_out  <= link;
              state         <= EMIT;
            end else begin
              state <= SETTLE;
            end
          end
        end

        SETTLE: begin
          // Raising valid on the count-of-1 edge gives exactly XGEN_LAT
          // cycles between the capture edge and valid.
          if (settle_cnt <= 4'd1) begin
            settle_cnt    <= '0;
            out_valid_out <= 1'b1;
            out_link_out  <= link;
            state         <= EMIT;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        EMIT: begin
          if (out_ready_in) begin
            out_valid_out <= 1'b0;
            if (last_link) begin
              xg_sel_out <= '0;
              done_out   <= 1'b1;
              state      <= DONE;
            end else begin
              link        <= next_link;
              sc_req_out  <= 1'b1;
              sc_link_out <= next_link;
              state       <= FETCH;
            end
          end
        end

        DONE: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef XGEN_SCHED_PERF_EN
  logic [15:0] cyc_cnt;

  // Run length counter: cleared by an accepted start, counts every busy
  // cycle (including DONE), saturates, and holds until the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if (state == IDLE && start_in) begin
      cyc_cnt <= '0;
    end else if (busy_out && cyc_cnt != 16'hFFFF) begin
      cyc_cnt <= cyc_cnt + 16'd1;
    end
  end

  assign cyc_cnt_out = cyc_cnt;
`else
  assign cyc_cnt_out = 16'd0;
`endif

endmodule
